// File: rtl/hdmi_clkrst.sv
// Serial-clock housekeeping: lock synchroniser, divide-by-DIV pixel phase, pixel-aligned
// video reset release and lock-loss tracking. HDMI_CLKRST_LOSSCNT_EN builds the loss counter.
module hdmi_clkrst #(
    parameter int DIV           = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       lock_lost_clr,
    output logic       pix_rst,
    output logic       pix_ce,
    output logic [3:0] phase,
    output logic       lock_lost,
    output logic [7:0] loss_cnt
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       PH_LAST  = 4'(DIV - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   lock_s;
    logic [CNT_W-1:0]       settle_cnt, cnt_nxt;
    logic                   lost_evt;

    assign lock_s = sync_pipe[SYNC_STAGES-1];
    assign pix_ce = (phase == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pipe <= '0;
            phase     <= 4'd0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pll_lock};
            phase     <= (phase == PH_LAST) ? 4'd0 : phase + 4'd1;
        end
    end

    // Release only on the edge where phase wraps, so video starts on a pixel boundary.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = settle_cnt;
        lost_evt  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (settle_cnt == CNT_LAST && phase == PH_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (settle_cnt != CNT_LAST) begin
                    cnt_nxt = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    lost_evt  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            pix_rst    <= 1'b1;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= cnt_nxt;
            pix_rst    <= (state_nxt != RUN);
            if (lost_evt)           lock_lost <= 1'b1;
            else if (lock_lost_clr) lock_lost <= 1'b0;
        end
    end

`ifdef HDMI_CLKRST_LOSSCNT_EN
    always_ff @(posedge clk) begin
        if (reset)                              loss_cnt <= 8'd0;
        else if (lost_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
